prio_encoder_latched: RTL

- Parametrised, registered successor to the team's combinational 8x3 encoder.
- Requests arrive as an N-bit vector and are latched into a pending register.
- Pending requests are encoded one at a time into a binary index and presented on a valid/ready handshake.
- Each accepted index clears its pending bit. The block fronts the interrupt and event-dispatch logic.

---
 rtl/enc_pkg.sv | 19 +
 rtl/prio_select.sv | 40 ++++
 rtl/prio_encoder_latched.sv | 105 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types and helpers for the latched priority encoder.
package enc_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest request vector onehot() can describe; callers truncate to N.
  localparam int unsigned MAX_N = 1024;

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational selector: highest set bit, or first set bit at/after ptr with wrap.
module prio_select
  import enc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned PRIO_MODE = PRIO_FIXED,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic [N-1:0] v,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned j;
  logic        found;

  always_comb begin
    idx   = '0;
    any   = |v;
    found = 1'b0;
    j     = 0;
    if (PRIO_MODE == PRIO_RR) begin
      for (int unsigned k = 0; k < N; k++) begin
        j = 32'(ptr) + k;
        if (j >= N) j = j - N;
        if (!found && v[W'(j)]) begin
          idx   = W'(j);
          found = 1'b1;
        end
      end
    end else begin
      // Later (higher) hits overwrite earlier ones.
      for (int unsigned i = 0; i < N; i++) begin
        if (v[W'(i)]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_latched.sv
// Latches request lines into a pending set and grants them one at a time
// as a binary index over a valid/ready handshake.
module prio_encoder_latched
  import enc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned PRIO_MODE = PRIO_FIXED,
  localparam int unsigned W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  state_t       state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt, ptr_adv;
  logic [W-1:0] idx_nxt, pend_sel, rem_sel;
  logic         valid_nxt, ovf_nxt;
  logic         accept, pend_any, rem_any;
  logic [N-1:0] req, clr, rem, pend_nxt;

  // Selection on the registered pending set (entry from IDLE).
  prio_select #(.N(N), .PRIO_MODE(PRIO_MODE)) u_sel_pend (
    .v   (pending),
    .ptr (ptr),
    .idx (pend_sel),
    .any (pend_any)
  );

  // Selection on what survives this cycle's accept, using the advanced pointer.
  prio_select #(.N(N), .PRIO_MODE(PRIO_MODE)) u_sel_rem (
    .v   (rem),
    .ptr (ptr_adv),
    .idx (rem_sel),
    .any (rem_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pend_nxt;
      out_idx   <= idx_nxt;
      out_valid <= valid_nxt;
      overflow  <= ovf_nxt;
      ptr       <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = out_idx;
    valid_nxt = out_valid;
    ptr_nxt   = ptr;

    accept  = out_valid & out_ready;
    clr     = accept ? N'(onehot(32'(out_idx))) : '0;
    req     = en ? in : '0;
    rem     = pending & ~clr;
    ptr_adv = (32'(out_idx) == N - 1) ? '0 : out_idx + W'(1);

    // Set beats clear, so a re-request during its own accept survives.
    pend_nxt = rem | req;
    ovf_nxt  = |(req & rem);

    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (pend_any) begin
          idx_nxt   = pend_sel;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          ptr_nxt = ptr_adv;
          if (rem_any) begin
            idx_nxt = rem_sel;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
